// File: rtl/mult_ssd_seq.sv
// Sequential shift-add multiplier with double-dabble BCD and 7-seg readout; done 3*WIDTH+1 cycles after start.
// start is sampled only in IDLE (ignored while busy, never queued); outputs are registered and hold between jobs.
module mult_ssd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5,
  parameter int LZB    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   dig
);

  localparam int PW = 2 * WIDTH;
  // 0.3 underestimates log10(2) by too little to matter for PW <= 32
  localparam int ND = (PW * 3) / 10 + 1;
  localparam int NB = (ND > DIGITS) ? ND : DIGITS;
  localparam int BW = 4 * NB;
  localparam int CW = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_CONV,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [BW+PW-1:0]     sreg_q, sreg_d;
  logic [PW-1:0]        product_q, product_d;
  logic                 overflow_q, overflow_d;
  logic [7*DIGITS-1:0]  dig_q, dig_d;

  logic [BW+PW-1:0]     sreg_adj;
  logic                 ovf;
  logic                 nz;
  logic [3:0]           dgt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    sreg_d     = sreg_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    dig_d      = dig_q;
    sreg_adj   = sreg_q;
    ovf        = 1'b0;
    nz         = 1'b0;
    dgt        = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, in1};
          mplier_d = in2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MULT;
        end
      end

      S_MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          sreg_d  = {{BW{1'b0}}, acc_d};
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        if (cnt_q != CW'(PW)) begin
          for (int j = 0; j < NB; j++) begin
            if (sreg_adj[PW+4*j +: 4] >= 4'd5)
              sreg_adj[PW+4*j +: 4] = sreg_adj[PW+4*j +: 4] + 4'd3;
          end
          sreg_d = sreg_adj << 1;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          // Conversion finished last cycle; this cycle formats the display from the settled BCD.
          product_d = acc_q;
          for (int i = DIGITS; i < NB; i++) begin
            if (sreg_q[PW+4*i +: 4] != 4'd0) ovf = 1'b1;
          end
          overflow_d = ovf;
          for (int i = DIGITS - 1; i >= 0; i--) begin
            dgt = sreg_q[PW+4*i +: 4];
            if (dgt != 4'd0) nz = 1'b1;
            if (ovf)
              dig_d[7*i +: 7] = 7'b0111111;
            else if ((LZB != 0) && !nz && (i != 0))
              dig_d[7*i +: 7] = 7'b1111111;
            else
              dig_d[7*i +: 7] = seg7(dgt);
          end
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      sreg_q     <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      dig_q      <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      sreg_q     <= sreg_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      dig_q      <= dig_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;
  assign dig      = dig_q;

endmodule

// File: tb/tb_mult_ssd_seq.sv
// Scoreboard bench: two multiplier instances (8-bit/4 digits/blanking, 4-bit/3 digits/no blanking) against a decimal model.
module tb_mult_ssd_seq;

  localparam int WA = 8, DA = 4, LA = 1;
  localparam int WB = 4, DB = 3, LB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_a = 1'b0;
  logic [WA-1:0]     in1_a = '0, in2_a = '0;
  logic              busy_a, done_a, overflow_a;
  logic [2*WA-1:0]   product_a;
  logic [7*DA-1:0]   dig_a;

  logic              start_b = 1'b0;
  logic [WB-1:0]     in1_b = '0, in2_b = '0;
  logic              busy_b, done_b, overflow_b;
  logic [2*WB-1:0]   product_b;
  logic [7*DB-1:0]   dig_b;

  mult_ssd_seq #(.WIDTH(WA), .DIGITS(DA), .LZB(LA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in1(in1_a), .in2(in2_a),
    .busy(busy_a), .done(done_a), .product(product_a), .overflow(overflow_a), .dig(dig_a)
  );

  mult_ssd_seq #(.WIDTH(WB), .DIGITS(DB), .LZB(LB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in1(in1_b), .in2(in2_b),
    .busy(busy_b), .done(done_b), .product(product_b), .overflow(overflow_b), .dig(dig_b)
  );

  typedef struct {
    longint      prod;
    bit          ovf;
    logic [69:0] dig;
    int          due;
  } exp_t;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  exp_t qa[$], qb[$];
  exp_t hold_a, hold_b;
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   rst_q = 1'b0;
  int   nf_a = 0, nf_b = 0;
  int   la_a = -1000, la_b = -1000;
  int   last_rst = -1;
  bit   mon_a = 1'b0, mon_b = 1'b0;
  bit   ed_a, eb_a, ed_b, eb_b;

  // Expected display computed from the decimal value of the product.
  function automatic exp_t model(input longint a, input longint b, input int digits, input int lzb, input int due);
    exp_t   e;
    longint p;
    e.prod = a * b;
    e.due  = due;
    e.dig  = '0;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    e.ovf = (e.prod >= p);
    p = 1;
    for (int i = 0; i < digits; i++) begin
      if (e.ovf)
        e.dig[7*i +: 7] = 7'b0111111;
      else if ((lzb != 0) && (i > 0) && (e.prod < p))
        e.dig[7*i +: 7] = 7'b1111111;
      else
        e.dig[7*i +: 7] = SEG_TBL[int'((e.prod / p) % 10)];
      p = p * 10;
    end
    return e;
  endfunction

  function automatic exp_t rst_val(input int digits);
    exp_t e;
    e.prod = 0;
    e.ovf  = 1'b0;
    e.due  = 0;
    e.dig  = '0;
    for (int i = 0; i < digits; i++) e.dig[7*i +: 7] = 7'b1111111;
    return e;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      mon_a  = 1'b1;
      hold_a = rst_val(DA);
    end
    if (mon_a) begin
      ed_a = (qa.size() > 0) && (qa[0].due == cyc);
      if (ed_a) hold_a = qa.pop_front();
      eb_a = (cyc >= la_a) && (cyc <= la_a + 3*WA + 1) && !((last_rst > la_a) && (cyc >= last_rst));
      chk("a_done",     80'(done_a),     80'(ed_a));
      chk("a_busy",     80'(busy_a),     80'(eb_a));
      chk("a_product",  80'(product_a),  80'(hold_a.prod));
      chk("a_overflow", 80'(overflow_a), 80'(hold_a.ovf));
      chk("a_dig",      80'(dig_a),      80'(hold_a.dig));
    end
  end

  always @(negedge clk) begin
    if (rst_q) begin
      mon_b  = 1'b1;
      hold_b = rst_val(DB);
    end
    if (mon_b) begin
      ed_b = (qb.size() > 0) && (qb[0].due == cyc);
      if (ed_b) hold_b = qb.pop_front();
      eb_b = (cyc >= la_b) && (cyc <= la_b + 3*WB + 1) && !((last_rst > la_b) && (cyc >= last_rst));
      chk("b_done",     80'(done_b),     80'(ed_b));
      chk("b_busy",     80'(busy_b),     80'(eb_b));
      chk("b_product",  80'(product_b),  80'(hold_b.prod));
      chk("b_overflow", 80'(overflow_b), 80'(hold_b.ovf));
      chk("b_dig",      80'(dig_b),      80'(hold_b.dig));
    end
  end

  // Drives one clock of inputs; the model decides whether start is taken at the coming edge.
  task automatic tick(input bit sa, input int a1, input int a2, input bit sb, input int b1, input int b2,
                      input bit r, output bit acca, output bit accb);
    int e;
    @(posedge clk);
    #1;
    e       = cyc + 1;
    rst     = r;
    start_a = sa;
    in1_a   = a1[WA-1:0];
    in2_a   = a2[WA-1:0];
    start_b = sb;
    in1_b   = b1[WB-1:0];
    in2_b   = b2[WB-1:0];
    if (r) begin
      for (int i = qa.size() - 1; i >= 0; i--) if (qa[i].due >= e) qa.delete(i);
      for (int i = qb.size() - 1; i >= 0; i--) if (qb[i].due >= e) qb.delete(i);
      nf_a     = e + 1;
      nf_b     = e + 1;
      last_rst = e;
    end
    acca = sa && !r && (e >= nf_a);
    accb = sb && !r && (e >= nf_b);
    if (acca) begin
      qa.push_back(model(longint'(a1 & ((1 << WA) - 1)), longint'(a2 & ((1 << WA) - 1)), DA, LA, e + 3*WA + 1));
      la_a = e;
      nf_a = e + 3*WA + 3;
    end
    if (accb) begin
      qb.push_back(model(longint'(b1 & ((1 << WB) - 1)), longint'(b2 & ((1 << WB) - 1)), DB, LB, e + 3*WB + 1));
      la_b = e;
      nf_b = e + 3*WB + 3;
    end
  endtask

  task automatic idle(input int n);
    bit aa, ab;
    repeat (n) tick(1'b0, $urandom, $urandom, 1'b0, $urandom, $urandom, 1'b0, aa, ab);
  endtask

  // One job on instance inst; with spam, operands churn and start pulses hit the busy window including DONE.
  task automatic job(input bit inst, input int x, input int y, input bit spam);
    bit aa, ab, got, st;
    int tries, n;
    tries = 0;
    got   = 1'b0;
    while (!got && tries < 200) begin
      if (inst == 1'b0) tick(1'b1, x, y, 1'b0, $urandom, $urandom, 1'b0, aa, ab);
      else              tick(1'b0, $urandom, $urandom, 1'b1, x, y, 1'b0, aa, ab);
      got = (inst == 1'b0) ? aa : ab;
      tries++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL job_accept at cycle %0d: start not taken within 200 cycles", cyc);
    end
    n = (inst == 1'b0) ? 3*WA + 2 : 3*WB + 2;
    for (int i = 0; i < n; i++) begin
      st = spam && ((i == n - 1) || ($urandom % 3 == 0));
      if (inst == 1'b0) tick(st, $urandom, $urandom, 1'b0, $urandom, $urandom, 1'b0, aa, ab);
      else              tick(1'b0, $urandom, $urandom, st, $urandom, $urandom, 1'b0, aa, ab);
    end
  endtask

  int dir_a [9][2] = '{'{13, 11}, '{0, 200}, '{255, 255}, '{200, 100}, '{99, 99},
                       '{7, 3}, '{10, 100}, '{1, 0}, '{255, 1}};

  initial begin
    bit aa, ab;
    repeat (3) tick(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, aa, ab);
    idle(20);

    for (int i = 0; i < 9; i++) job(1'b0, dir_a[i][0], dir_a[i][1], 1'b1);
    for (int i = 0; i < 25; i++) job(1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);

    // start held high on both instances: back-to-back jobs with operands changing every cycle
    repeat (120) tick(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b0, aa, ab);
    idle(3*WA + 4);

    // reset while both instances are converting
    tick(1'b1, 77, 91, 1'b1, 13, 14, 1'b0, aa, ab);
    idle(WA + 4);
    tick(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, aa, ab);
    idle(40);
    job(1'b0, 77, 91, 1'b0);
    job(1'b1, 13, 14, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        job(1'b1, a, b, 1'b0);

    idle(40);
    chk("a_queue_drained", 80'(qa.size()), 80'd0);
    chk("b_queue_drained", 80'(qb.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
